// File: rtl/encoder_42_seq_if.sv
// Request/response bundle for encoder_42_seq.
// slave  : the encoder (samples w/EN/ack, drives out/valid/err)
// master : the request source / consumer side
interface encoder_42_seq_if;
  logic [3:0] w;
  logic       EN;
  logic       ack;
  logic [1:0] out;
  logic       valid;
  logic       err;

  modport slave  (input  w, EN, ack, output out, valid, err);
  modport master (output w, EN, ack, input  out, valid, err);
endinterface

// File: rtl/encoder_42_seq.sv
// Sequential 4-to-2 priority encoder with debounce and valid/ack handshake.
// A nonzero request pattern must hold for STABLE_CYC edges before the code of
// the highest asserted line is latched and presented; the lines must then be
// released before another request is accepted.
// Optional feature: define ENC42_ONEHOT_CHECK_EN to build multi-hot detection
// on err; otherwise err is tied to 0.
module encoder_42_seq #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  encoder_42_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // count value at which the pattern has been stable long enough
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_w_q;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_out;
  logic             r_valid;
  logic [1:0]       w_code;

  // highest asserted line wins
  always_comb begin
    w_code = 2'b00;
    casez (bus.w)
      4'b1???: w_code = 2'b11;
      4'b01??: w_code = 2'b10;
      4'b001?: w_code = 2'b01;
      default: w_code = 2'b00;
    endcase
  end

  // previous-cycle sample, used to detect a pattern change during settling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_w_q <= 4'b0000;
    else        r_w_q <= bus.w;
  end

  // control FSM: IDLE -> SETTLE -> PRESENT -> RELEASE -> IDLE; EN=0 forces IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= 2'b00;
      r_valid <= 1'b0;
    end else if (!bus.EN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.w != 4'b0000) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (bus.w == 4'b0000) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (bus.w != r_w_q) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_PRESENT;
            r_cnt   <= '0;
            r_out   <= w_code;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRESENT: begin
          // out/err stay frozen here regardless of w
          if (bus.ack) begin
            r_state <= S_RELEASE;
            r_valid <= 1'b0;
          end
        end
        S_RELEASE: begin
          // a held request is never re-encoded; wait for all lines low
          if (bus.w == 4'b0000) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out   = r_out;
  assign bus.valid = r_valid;

`ifdef ENC42_ONEHOT_CHECK_EN
  logic r_err;
  logic w_multi;

  // more than one line hot: clearing the lowest set bit leaves something
  assign w_multi = |(bus.w & (bus.w - 4'd1));

  // err captured alongside the code and held with valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (!bus.EN)
      r_err <= 1'b0;
    else if (r_state == S_SETTLE && bus.w != 4'b0000 && bus.w == r_w_q
             && r_cnt == CNT_LAST)
      r_err <= w_multi;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_42_seq.sv
// Randomized + directed bench for encoder_42_seq with a behavioural model and
// a scoreboard queue of expected codes popped when valid rises.
module tb_encoder_42_seq;
  localparam int STABLE_CYC = 4;
  localparam int CNT_W      = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  encoder_42_seq_if bus();

  encoder_42_seq #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [1:0] code; logic err; } exp_t;
  exp_t sb[$];

  int         m_run;   // number of consecutive identical nonzero samples
  logic       m_hold;  // a code is being presented
  logic       m_rel;   // waiting for all lines to drop
  logic       m_clr;   // EN=0 (or reset) seen: outputs must be zero
  logic [3:0] m_prev;

  function automatic exp_t ref_code(input logic [3:0] w);
    exp_t e;
    e.code = 2'b00;
    for (int i = 0; i < 4; i++) if (w[i]) e.code = 2'(i);
`ifdef ENC42_ONEHOT_CHECK_EN
    e.err = ($countones(w) > 1);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  initial begin
    m_run = 0; m_hold = 0; m_rel = 0; m_clr = 1; m_prev = 4'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_hold = 0; m_rel = 0; m_clr = 1; m_prev = 4'b0;
        sb.delete();
      end else begin
        m_clr = !bus.EN;
        if (!bus.EN) begin
          m_run = 0; m_hold = 0; m_rel = 0;
        end else if (m_hold) begin
          if (bus.ack) begin m_hold = 0; m_rel = 1; end
        end else if (m_rel) begin
          if (bus.w == 4'b0) m_rel = 0;
        end else begin
          if (bus.w == 4'b0) m_run = 0;
          else if (bus.w == m_prev && m_run > 0) m_run++;
          else m_run = 1;
          // first sample plus STABLE_CYC more identical ones
          if (m_run == STABLE_CYC + 1) begin
            m_hold = 1; m_run = 0;
            sb.push_back(ref_code(bus.w));
          end
        end
        m_prev = bus.w;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_v = 1'b0;
  exp_t cur;

  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        checks++;
        if (bus.valid !== m_hold) begin
          errors++;
          $display("FAIL valid: got %b expected %b at %0t", bus.valid, m_hold, $time);
        end
        if (bus.valid === 1'b1 && !prev_v) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL code_unexpected: got out=%b with no expected code at %0t", bus.out, $time);
          end else begin
            cur = sb.pop_front();
            if (bus.out !== cur.code || bus.err !== cur.err) begin
              errors++;
              $display("FAIL code: got out=%b err=%b expected out=%b err=%b at %0t",
                       bus.out, bus.err, cur.code, cur.err, $time);
            end
          end
        end else if (bus.valid === 1'b1) begin
          checks++;
          if (bus.out !== cur.code || bus.err !== cur.err) begin
            errors++;
            $display("FAIL frozen: got out=%b err=%b expected out=%b err=%b at %0t",
                     bus.out, bus.err, cur.code, cur.err, $time);
          end
        end
        if (m_clr) begin
          checks++;
          if (bus.out !== 2'b00 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL cleared: got out=%b err=%b expected 00/0 at %0t", bus.out, bus.err, $time);
          end
        end
        prev_v = bus.valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] w, input logic en, input logic ak);
    @(negedge clk);
    bus.w = w; bus.EN = en; bus.ack = ak;
  endtask

  task automatic wait_valid(input string name, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: valid not seen within %0d cycles (expected 1)", name, max);
    end
  endtask

  task automatic serve(input string name, input logic [3:0] w);
    step(w, 1, 0);
    wait_valid(name, 12);
    step(w, 1, 1);
    step(4'b0, 1, 0);
    step(4'b0, 1, 0);
  endtask

  initial begin
    bus.w = 4'b0; bus.EN = 1'b0; bus.ack = 1'b0;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.out !== 2'b00 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b out=%b err=%b expected 0/00/0", bus.valid, bus.out, bus.err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(4'b0, 1, 0);

    // basic encode, multi-hot, restart on pattern change
    serve("enc0100", 4'b0100);
    serve("enc1010", 4'b1010);
    step(4'b0001, 1, 0); step(4'b0001, 1, 0);
    serve("restart", 4'b0010);

    // frozen output while presenting, no re-encode of held request
    step(4'b0001, 1, 0);
    wait_valid("frz", 12);
    repeat (3) step(4'b1000, 1, 0);
    step(4'b1000, 1, 1);
    repeat (8) step(4'b1000, 1, 0);
    step(4'b0, 1, 0); step(4'b0, 1, 0);
    serve("repress", 4'b1000);

    // EN=0 during settle, then during present with simultaneous ack
    step(4'b0100, 1, 0); step(4'b0100, 1, 0);
    step(4'b0100, 0, 0);
    step(4'b0, 1, 0); step(4'b0, 1, 0);
    step(4'b0110, 1, 0);
    wait_valid("en_off", 12);
    step(4'b0110, 0, 1);
    step(4'b0, 1, 0); step(4'b0, 1, 0);

    // asynchronous reset while presenting
    step(4'b1001, 1, 0);
    wait_valid("rst_mid", 12);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.out !== 2'b00 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b out=%b err=%b expected 0/00/0", bus.valid, bus.out, bus.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0, 1, 0); step(4'b0, 1, 0);

    // randomized traffic
    begin
      logic [3:0] wr = 4'b0;
      logic [3:0] rv;
      logic en, ak;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 5) == 0) begin
          rv = 4'($urandom_range(0, 15));
          wr = ($urandom_range(0, 3) == 0) ? 4'b0 : rv;
        end
        en = ($urandom_range(0, 60) != 0);
        ak = ($urandom_range(0, 3) == 0);
        step(wr, en, ak);
      end
    end

    repeat (4) step(4'b0, 1, 1);
    step(4'b0, 1, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected codes never presented (expected 0)", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/encoder_42_seq.md
# encoder_42_seq

Sequential 4-to-2 encoder with enable: the encoding-side counterpart of the team's 2-to-4 decoder. It samples four request lines, requires a request pattern to stay stable for a programmable number of cycles, and then latches the 2-bit code of the highest asserted line. It presents that code with a valid/ack handshake and waits for all lines to release before accepting a new request. It sits between raw request sources (switches, keypad rows, one-hot control lines) and logic that consumes a binary index, typically feeding a `decoder_24` downstream.

## Interface
- `STABLE_CYC`, default 4: consecutive cycles a nonzero pattern must hold before encoding; legal range 1..(2^CNT_W − 1).
- `CNT_W`, default 3: stability counter width.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `w`  input  4  request lines; bit i asserted requests code i.
- `EN`  input  1  enable; 0 forces the block idle.
- `ack`  input  1  consumer accepts the presented code.
- `out`  output  2  encoded index, valid while `valid`=1.
- `valid`  output  1  code presented, held until `ack`.
- `err`  output  1  more than one line was hot in the captured pattern (see Configuration).

## Operation
- Reset (asynchronous, `rst_n`=0): state IDLE, `out`=2'b00, `valid`=0, `err`=0, sample register `w_q`=4'b0000, counter `cnt`=0.
- Every edge: `w_q` <= `w`.
- FSM states and transitions:
  - IDLE: if `EN`=1 and `w`≠0, go to SETTLE with `cnt`=0.
  - SETTLE: if `w`==`w_q` and `w`≠0, `cnt`++. If `w` changes, or goes to 0, `cnt`=0 (and go to IDLE if `w`=0). When `w`==`w_q` at `cnt`==STABLE_CYC−1, go to PRESENT and latch `out` and `err`.
  - PRESENT: `valid`=1. `out` and `err` are frozen even if `w` changes. On `ack`=1, go to RELEASE.
  - RELEASE: `valid`=0. Once `w`==0 is sampled, go to IDLE. A held request is never re-encoded.
- Priority: the highest asserted bit wins. 4'b1xxx→2'b11, 4'b01xx→2'b10, 4'b001x→2'b01, 4'b0001→2'b00.
- `EN`=0 in any state: the next edge goes to IDLE with `out`=2'b00, `valid`=0, `err`=0. `EN`=0 wins over a simultaneous `ack`.
- `ack` while `valid`=0 is ignored.

## Timing
- A pattern first sampled at edge k (and held) produces `valid`=1 and `out` after edge k+STABLE_CYC.
- `valid` deasserts at the first edge where `ack`=1 is sampled. It is never low for zero cycles between two codes, because a new code requires RELEASE→IDLE→SETTLE.
- A single-cycle glitch on `w` during SETTLE restarts the count. Minimum time from glitch end to `valid` is STABLE_CYC+1 edges.
- Reset mid-handshake drops `valid` immediately (asynchronous). No pending code survives reset.
- STABLE_CYC=1: `valid` rises after edge k+1.

## Configuration
- `ENC42_ONEHOT_CHECK_EN` defined: at capture, `err`=1 if more than one bit of `w` is set, else 0. `err` is valid and held with `valid`. The code still follows priority.
- Not defined: `err` is tied to 0 and no multi-hot detection logic is built. Priority encoding is unchanged.

## Test plan
- Reset then `EN`=1, `w`=4'b0100 held from edge 10, STABLE_CYC=4 → `valid`=1 and `out`=2'b10 after edge 14; `ack` at edge 16 → `valid`=0 after edge 16; `w`=0 → IDLE.
- `w`=4'b1010 held (macro defined) → `out`=2'b11, `err`=1. Same test with the macro undefined → `out`=2'b11, `err`=0.
- `w`=4'b0001 for 2 cycles, then 4'b0010 held → count restarts; `out`=2'b01 appears 4 edges after 4'b0010 is first sampled.
- In PRESENT with `out`=2'b00, change `w` to 4'b1000 → `out` stays 2'b00 until `ack`. After `ack`, with `w` still held, no new `valid`; release then re-press 4'b1000 → `out`=2'b11.
- `EN`=0 asserted in SETTLE and in PRESENT (with simultaneous `ack`) → next edge: IDLE, `out`=2'b00, `valid`=0, `err`=0.
- `rst_n` pulsed low mid-PRESENT between edges → `valid`, `out`, and `err` go to 0 immediately, without waiting for a clock edge.
